// File: rtl/jedro_1_trap_ctrl.sv
// Trap controller: sequences exception entry (flush, CSR write, vector jump)
// and MRET return (flush plus jump to mepc) for the jedro_1 core.
module jedro_1_trap_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        illegal_instr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic [31:0] instr_addr_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        busy_o,
    output logic        flush_o,
    output logic        trap_we_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic        jmp_o,
    output logic [31:0] jmp_addr_o
);
    typedef enum logic [2:0] {IDLE, FLUSH, CSR_WR, JUMP, RET} state_t;

    state_t      state_q;
    logic        busy_q, flush_q, we_q, jmp_q, ret_q;
    logic [31:0] mepc_q, mcause_q, mtval_q;
    logic        exc;
    logic [31:0] mcause_d, mtval_d;

    assign exc = illegal_instr_i | ebreak_i | ecall_i;

    // Only one cause is latched: illegal wins over ebreak, ebreak over ecall.
    always_comb begin
        mcause_d = 32'd11;
        mtval_d  = 32'd0;
        if (illegal_instr_i) begin
            mcause_d = 32'd2;
            mtval_d  = instr_i;
        end else if (ebreak_i) begin
            mcause_d = 32'd3;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            flush_q  <= 1'b0;
            we_q     <= 1'b0;
            jmp_q    <= 1'b0;
            ret_q    <= 1'b0;
            mepc_q   <= 32'd0;
            mcause_q <= 32'd0;
            mtval_q  <= 32'd0;
        end else begin
            flush_q <= 1'b0;
            we_q    <= 1'b0;
            jmp_q   <= 1'b0;
            ret_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (exc) begin
                        mepc_q   <= {instr_addr_i[31:2], 2'b00};
                        mcause_q <= mcause_d;
                        mtval_q  <= mtval_d;
                        state_q  <= FLUSH;
                        busy_q   <= 1'b1;
                        flush_q  <= 1'b1;
                    end else if (mret_i) begin
                        state_q <= RET;
                        busy_q  <= 1'b1;
                        flush_q <= 1'b1;
                        jmp_q   <= 1'b1;
                        ret_q   <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    state_q <= CSR_WR;
                    we_q    <= 1'b1;
                end
                CSR_WR: begin
                    state_q <= JUMP;
                    jmp_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign flush_o   = flush_q;
    assign trap_we_o = we_q;
    assign jmp_o     = jmp_q;
    assign mepc_o    = mepc_q;
    assign mcause_o  = mcause_q;
    assign mtval_o   = mtval_q;

    // Target is taken live so a CSR update landing just before the jump is used.
    always_comb begin
        jmp_addr_o = 32'd0;
        if (jmp_q)
            jmp_addr_o = ret_q ? {mepc_i[31:2], 2'b00} : {mtvec_i[31:2], 2'b00};
    end
endmodule

// File: doc/jedro_1_trap_ctrl.md
JEDRO_1_TRAP_CTRL -- requirements
Module: jedro_1_trap_ctrl

Interface
REQ-001 The block SHALL have no parameters; all data paths are 32 bits wide.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 illegal_instr_i  input  1  decoder flags an illegal instruction, including access to a non-existent CSR.
REQ-005 ecall_i  input  1  decoder flags ECALL.
REQ-006 ebreak_i  input  1  decoder flags EBREAK.
REQ-007 mret_i  input  1  decoder flags MRET.
REQ-008 instr_addr_i  input  32  PC of the flagged instruction.
REQ-009 instr_i  input  32  encoding of the flagged instruction.
REQ-010 mtvec_i  input  32  current mtvec value from the CSR unit.
REQ-011 mepc_i  input  32  current mepc value from the CSR unit.
REQ-012 busy_o  output  1  trap sequence in progress; the decoder holds and issues nothing.
REQ-013 flush_o  output  1  kill all younger in-flight instructions.
REQ-014 trap_we_o  output  1  one-cycle strobe; the CSR unit writes mepc, mcause and mtval.
REQ-015 mepc_o, mcause_o, mtval_o  output  32 each  values for the CSR write.
REQ-016 jmp_o  output  1  one-cycle fetch redirect strobe.
REQ-017 jmp_addr_o  output  32  redirect target.

Function
REQ-018 The FSM SHALL have the states IDLE, FLUSH, CSR_WR, JUMP and RET.
REQ-019 Event inputs SHALL be sampled only in IDLE; events in any other state are ignored.
REQ-020 In IDLE with any exception asserted, the block SHALL latch the cause, instr_addr_i and instr_i, then move to FLUSH.
REQ-021 Exception priority SHALL be illegal > ebreak > ecall, with one cause latched.
REQ-022 mcause values: illegal = 2, ebreak = 3, ecall = 11, with bit 31 = 0.
REQ-023 mtval SHALL be instr_i for illegal and 0 for ebreak and ecall; mepc SHALL be instr_addr_i with bits [1:0] forced to 0.
REQ-024 In IDLE with mret_i only (no exception), the block SHALL go to RET; an exception takes precedence over mret_i in the same cycle.
REQ-025 FLUSH: flush_o = 1 and busy_o = 1 for exactly one cycle, then CSR_WR.
REQ-026 CSR_WR: trap_we_o = 1 for exactly one cycle with the latched mepc_o, mcause_o and mtval_o; busy_o = 1; then JUMP.
REQ-027 JUMP: jmp_o = 1 and jmp_addr_o = {mtvec_i[31:2], 2'b00} (direct mode only; the mode bits are ignored); busy_o = 1; then IDLE.
REQ-028 RET: flush_o = 1, jmp_o = 1 and jmp_addr_o = {mepc_i[31:2], 2'b00}, all in one cycle; busy_o = 1; then IDLE.
REQ-029 Latency from an exception sampled at edge N: flush at N+1, CSR write at N+2, redirect at N+3, and the block accepts events again at N+4.
REQ-030 mtvec_i SHALL be read in the JUMP cycle, so a same-sequence CSR update is seen; mepc_i SHALL be read in the RET cycle.
REQ-031 Outside the cycles defined above, flush_o, trap_we_o and jmp_o SHALL be 0 and jmp_addr_o SHALL be 0.
REQ-032 mepc_o, mcause_o and mtval_o SHALL hold their last latched values between traps.

Reset
REQ-033 While rst_i = 1 at a clock edge, the state SHALL become IDLE and all outputs and latched registers SHALL become 0.
REQ-034 A reset asserted in any state, including mid-sequence, SHALL abort the sequence with no pending write or jump issued afterwards.
REQ-035 An event input asserted in the first cycle after reset release SHALL be accepted normally.

Verification
REQ-036 Illegal instruction: illegal_instr_i = 1, instr_addr_i = 0x0000_0010, instr_i = 0x3420_2073, mtvec_i = 0x0000_0100 -> flush at N+1; trap_we with mepc 0x10, mcause 2, mtval 0x3420_2073 at N+2; jmp to 0x100 at N+3.
REQ-037 Simultaneous events: illegal_instr_i = ecall_i = ebreak_i = mret_i = 1 -> mcause 2 and no RET.
REQ-038 ECALL then MRET: ecall at PC 0x20 -> mcause 11, mtval 0; then mret_i with mepc_i = 0x24 -> one-cycle flush, jmp to 0x24, busy for 1 cycle.
REQ-039 Event during busy: ebreak_i pulsed in FLUSH and CSR_WR -> ignored; exactly one trap_we, with mcause 3 only if ebreak_i was also high in IDLE.
REQ-040 Mode bits and misalignment: mtvec_i = 0x0000_0201 -> jmp_addr 0x200; instr_addr_i = 0x0000_0013 -> mepc 0x10.
REQ-041 Reset mid-operation: rst_i = 1 during CSR_WR -> next cycle all outputs 0, no jmp_o; a new illegal instruction after release -> full sequence at N+1..N+3.
